sm83_regfile: RTL and testbench

Parametrised SM83 register file replacing the bare register-vector typedef with a clocked storage block.
- Holds A, F, B, C, D, E, H, L, SP, PC and IR.
- Multi-port combinational reads; 8-bit, 16-bit and flag-masked writes.
- Integrated increment/decrement unit (IDU) for pair/SP/PC post-modify.
- Sits between the SM83 decoder/sequencer and the ALU/bus interface.

---
 rtl/sm83_pkg.sv | 52 +++++
 rtl/sm83_idu.sv | 15 +
 rtl/sm83_regfile.sv | 187 ++++++++++++++++++
 tb/tb_sm83_regfile.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_pkg.sv
// Shared SM83 register-file types.
//   r8_sel_e  : 8-bit register select, hardware operand encoding (6 = none)
//   r16_sel_e : 16-bit register select (BC, DE, HL, SP, AF)
//   idu_sel_e : increment/decrement unit target
//   FLAG_*    : flag positions within the {Z,N,H,C} nibble
//   byte_t / pair_t : byte and {msb,lsb} pair storage types
package sm83_pkg;

  typedef enum logic [2:0] {
    R8_B    = 3'd0,
    R8_C    = 3'd1,
    R8_D    = 3'd2,
    R8_E    = 3'd3,
    R8_H    = 3'd4,
    R8_L    = 3'd5,
    R8_NONE = 3'd6,
    R8_A    = 3'd7
  } r8_sel_e;

  typedef enum logic [2:0] {
    R16_BC = 3'd0,
    R16_DE = 3'd1,
    R16_HL = 3'd2,
    R16_SP = 3'd3,
    R16_AF = 3'd4
  } r16_sel_e;

  typedef enum logic [1:0] {
    IDU_BC = 2'd0,
    IDU_DE = 2'd1,
    IDU_HL = 2'd2,
    IDU_SP = 2'd3
  } idu_sel_e;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_H = 1;
  localparam int unsigned FLAG_C = 0;

  typedef logic [7:0] byte_t;

  typedef struct packed {
    byte_t msb;
    byte_t lsb;
  } pair_t;

  // F only ever holds flags in its upper nibble.
  function automatic byte_t f_clean(byte_t f);
    return {f[7:4], 4'h0};
  endfunction

endpackage

// File: rtl/sm83_idu.sv
// SM83 increment/decrement unit: 16-bit +1 / -1 with natural wrap, no flags.
//   din  : operand
//   dec  : 1 = decrement, 0 = increment
//   dout : result
module sm83_idu (
  input  logic [15:0] din,
  input  logic        dec,
  output logic [15:0] dout
);

  always_comb begin
    dout = dec ? (din - 16'd1) : (din + 16'd1);
  end

endmodule

// File: rtl/sm83_regfile.sv
// SM83 register file: A, F, BC, DE, HL, SP, PC, IR with combinational
// multi-port reads and clocked writes.
//   clk, rst               : clock, synchronous active-high reset
//   rd8_sel/rd8_data       : N_RD8 8-bit read ports (select 6 reads 0)
//   rd16_sel/rd16_data     : N_RD16 16-bit read ports (selects 5-7 read 0)
//   wr8_*, wr16_*          : 8-bit and 16-bit write ports
//   f_wmask/f_wdata        : per-flag writes {Z,N,H,C}
//   idu_*                  : pair/SP post-increment/decrement
//   pc_wen/pc_wdata/pc_inc : PC load / increment
//   ir_wen/ir_wdata        : instruction register load
//   a_q, f_q, pc_q, sp_q, ir_q : direct register views
module sm83_regfile
  import sm83_pkg::*;
#(
  parameter int          N_RD8  = 2,
  parameter int          N_RD16 = 1,
  parameter logic [15:0] RST_AF = 16'h01B0,
  parameter logic [15:0] RST_BC = 16'h0013,
  parameter logic [15:0] RST_DE = 16'h00D8,
  parameter logic [15:0] RST_HL = 16'h014D,
  parameter logic [15:0] RST_SP = 16'hFFFE,
  parameter logic [15:0] RST_PC = 16'h0100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*N_RD8-1:0]    rd8_sel,
  output logic [8*N_RD8-1:0]    rd8_data,
  input  logic [3*N_RD16-1:0]   rd16_sel,
  output logic [16*N_RD16-1:0]  rd16_data,
  input  logic                  wr8_en,
  input  logic [2:0]            wr8_sel,
  input  logic [7:0]            wr8_data,
  input  logic                  wr16_en,
  input  logic [2:0]            wr16_sel,
  input  logic [15:0]           wr16_data,
  input  logic [3:0]            f_wmask,
  input  logic [3:0]            f_wdata,
  input  logic                  idu_en,
  input  logic [1:0]            idu_sel,
  input  logic                  idu_dec,
  input  logic                  pc_wen,
  input  logic [15:0]           pc_wdata,
  input  logic                  pc_inc,
  input  logic                  ir_wen,
  input  logic [7:0]            ir_wdata,
  output logic [7:0]            a_q,
  output logic [7:0]            f_q,
  output logic [15:0]           pc_q,
  output logic [15:0]           sp_q,
  output logic [7:0]            ir_q
);

  pair_t bc_q, de_q, hl_q;
  pair_t bc_d, de_d, hl_d;
  byte_t a_d, f_d, ir_d;
  logic [15:0] sp_d, pc_d;
  logic [15:0] idu_src, idu_res;

  // Read ports
  always_comb begin
    rd8_data = '0;
    for (int i = 0; i < N_RD8; i++) begin
      case (rd8_sel[3*i +: 3])
        R8_B:    rd8_data[8*i +: 8] = bc_q.msb;
        R8_C:    rd8_data[8*i +: 8] = bc_q.lsb;
        R8_D:    rd8_data[8*i +: 8] = de_q.msb;
        R8_E:    rd8_data[8*i +: 8] = de_q.lsb;
        R8_H:    rd8_data[8*i +: 8] = hl_q.msb;
        R8_L:    rd8_data[8*i +: 8] = hl_q.lsb;
        R8_A:    rd8_data[8*i +: 8] = a_q;
        default: rd8_data[8*i +: 8] = 8'h00;
      endcase
    end
  end

  always_comb begin
    rd16_data = '0;
    for (int i = 0; i < N_RD16; i++) begin
      case (rd16_sel[3*i +: 3])
        R16_BC:  rd16_data[16*i +: 16] = bc_q;
        R16_DE:  rd16_data[16*i +: 16] = de_q;
        R16_HL:  rd16_data[16*i +: 16] = hl_q;
        R16_SP:  rd16_data[16*i +: 16] = sp_q;
        R16_AF:  rd16_data[16*i +: 16] = {a_q, f_q};
        default: rd16_data[16*i +: 16] = 16'h0000;
      endcase
    end
  end

  // IDU operand
  always_comb begin
    case (idu_sel)
      IDU_BC:  idu_src = bc_q;
      IDU_DE:  idu_src = de_q;
      IDU_HL:  idu_src = hl_q;
      default: idu_src = sp_q;
    endcase
  end

  sm83_idu u_idu (
    .din  (idu_src),
    .dec  (idu_dec),
    .dout (idu_res)
  );

  // Next state. Sources are applied lowest priority first so each higher
  // priority write overrides only the bytes it actually targets; untouched
  // bytes of a pair keep the lower-priority result.
  always_comb begin
    a_d  = a_q;
    f_d  = f_q;
    bc_d = bc_q;
    de_d = de_q;
    hl_d = hl_q;
    sp_d = sp_q;
    pc_d = pc_q;
    ir_d = ir_q;

    if (idu_en) begin
      case (idu_sel)
        IDU_BC:  bc_d = idu_res;
        IDU_DE:  de_d = idu_res;
        IDU_HL:  hl_d = idu_res;
        default: sp_d = idu_res;
      endcase
    end

    for (int i = 0; i < 4; i++) begin
      if (f_wmask[i]) f_d[4+i] = f_wdata[i];
    end

    if (wr8_en) begin
      case (wr8_sel)
        R8_B:    bc_d.msb = wr8_data;
        R8_C:    bc_d.lsb = wr8_data;
        R8_D:    de_d.msb = wr8_data;
        R8_E:    de_d.lsb = wr8_data;
        R8_H:    hl_d.msb = wr8_data;
        R8_L:    hl_d.lsb = wr8_data;
        R8_A:    a_d      = wr8_data;
        default: ;
      endcase
    end

    if (wr16_en) begin
      case (wr16_sel)
        R16_BC: bc_d = wr16_data;
        R16_DE: de_d = wr16_data;
        R16_HL: hl_d = wr16_data;
        R16_SP: sp_d = wr16_data;
        R16_AF: begin
          a_d = wr16_data[15:8];
          f_d = f_clean(wr16_data[7:0]);
        end
        default: ;
      endcase
    end

    if (pc_wen)      pc_d = pc_wdata;
    else if (pc_inc) pc_d = pc_q + 16'd1;

    if (ir_wen) ir_d = ir_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= RST_AF[15:8];
      f_q  <= f_clean(RST_AF[7:0]);
      bc_q <= RST_BC;
      de_q <= RST_DE;
      hl_q <= RST_HL;
      sp_q <= RST_SP;
      pc_q <= RST_PC;
      ir_q <= 8'h00;
    end else begin
      a_q  <= a_d;
      f_q  <= f_d;
      bc_q <= bc_d;
      de_q <= de_d;
      hl_q <= hl_d;
      sp_q <= sp_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

endmodule

// File: tb/tb_sm83_regfile.sv
module tb_sm83_regfile;

  logic        clk;
  logic        rst;
  logic [5:0]  rd8_sel;
  logic [15:0] rd8_data;
  logic [2:0]  rd16_sel;
  logic [15:0] rd16_data;
  logic        wr8_en;
  logic [2:0]  wr8_sel;
  logic [7:0]  wr8_data;
  logic        wr16_en;
  logic [2:0]  wr16_sel;
  logic [15:0] wr16_data;
  logic [3:0]  f_wmask, f_wdata;
  logic        idu_en;
  logic [1:0]  idu_sel;
  logic        idu_dec;
  logic        pc_wen;
  logic [15:0] pc_wdata;
  logic        pc_inc;
  logic        ir_wen;
  logic [7:0]  ir_wdata;
  logic [7:0]  a_q, f_q, ir_q;
  logic [15:0] pc_q, sp_q;

  sm83_regfile dut (
    .clk(clk), .rst(rst),
    .rd8_sel(rd8_sel), .rd8_data(rd8_data),
    .rd16_sel(rd16_sel), .rd16_data(rd16_data),
    .wr8_en(wr8_en), .wr8_sel(wr8_sel), .wr8_data(wr8_data),
    .wr16_en(wr16_en), .wr16_sel(wr16_sel), .wr16_data(wr16_data),
    .f_wmask(f_wmask), .f_wdata(f_wdata),
    .idu_en(idu_en), .idu_sel(idu_sel), .idu_dec(idu_dec),
    .pc_wen(pc_wen), .pc_wdata(pc_wdata), .pc_inc(pc_inc),
    .ir_wen(ir_wen), .ir_wdata(ir_wdata),
    .a_q(a_q), .f_q(f_q), .pc_q(pc_q), .sp_q(sp_q), .ir_q(ir_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte array in operand encoding, F kept in slot 6.
  logic [7:0]  m [8];
  logic [15:0] msp, mpc;
  logic [7:0]  mir;

  function automatic int hidx(input int s);
    return (s == 4) ? 7 : 2 * s;
  endfunction

  function automatic int lidx(input int s);
    return (s == 4) ? 6 : 2 * s + 1;
  endfunction

  function automatic logic [7:0] mread8(input logic [2:0] s);
    return (s == 3'd6) ? 8'h00 : m[s];
  endfunction

  function automatic logic [15:0] mread16(input logic [2:0] s);
    if (s == 3'd3) return msp;
    if (s > 3'd4)  return 16'h0000;
    return {m[hidx(int'(s))], m[lidx(int'(s))]};
  endfunction

  task automatic model_reset();
    m[7] = 8'h01; m[6] = 8'hB0;
    m[0] = 8'h00; m[1] = 8'h13;
    m[2] = 8'h00; m[3] = 8'hD8;
    m[4] = 8'h01; m[5] = 8'h4D;
    msp = 16'hFFFE; mpc = 16'h0100; mir = 8'h00;
  endtask

  // Priority resolved by claiming bytes from the highest-priority source down.
  task automatic model_step();
    logic [7:0]  n [8];
    logic [15:0] nsp, v, r;
    bit          cl [8];
    bit          spc;
    int          hi, lo;
    if (rst) begin
      model_reset();
      return;
    end
    n = m; nsp = msp; spc = 0;
    for (int i = 0; i < 8; i++) cl[i] = 0;
    if (wr16_en && wr16_sel <= 3'd4) begin
      if (wr16_sel == 3'd3) begin
        nsp = wr16_data; spc = 1;
      end else begin
        hi = hidx(int'(wr16_sel)); lo = lidx(int'(wr16_sel));
        n[hi] = wr16_data[15:8];
        n[lo] = (wr16_sel == 3'd4) ? (wr16_data[7:0] & 8'hF0) : wr16_data[7:0];
        cl[hi] = 1; cl[lo] = 1;
      end
    end
    if (wr8_en && wr8_sel != 3'd6 && !cl[wr8_sel]) begin
      n[wr8_sel] = wr8_data; cl[wr8_sel] = 1;
    end
    if (!cl[6])
      for (int i = 0; i < 4; i++) if (f_wmask[i]) n[6][4+i] = f_wdata[i];
    if (idu_en) begin
      if (idu_sel == 2'd3) begin
        if (!spc) nsp = idu_dec ? msp - 16'd1 : msp + 16'd1;
      end else begin
        hi = hidx(int'(idu_sel)); lo = lidx(int'(idu_sel));
        v = {m[hi], m[lo]};
        r = idu_dec ? v - 16'd1 : v + 16'd1;
        if (!cl[hi]) n[hi] = r[15:8];
        if (!cl[lo]) n[lo] = r[7:0];
      end
    end
    if (pc_wen)      mpc = pc_wdata;
    else if (pc_inc) mpc = mpc + 16'd1;
    if (ir_wen) mir = ir_wdata;
    m = n; msp = nsp;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; rd8_sel = 6'd0; rd16_sel = 3'd0;
    wr8_en = 1'b0; wr8_sel = 3'd0; wr8_data = 8'h00;
    wr16_en = 1'b0; wr16_sel = 3'd0; wr16_data = 16'h0000;
    f_wmask = 4'h0; f_wdata = 4'h0;
    idu_en = 1'b0; idu_sel = 2'd0; idu_dec = 1'b0;
    pc_wen = 1'b0; pc_wdata = 16'h0000; pc_inc = 1'b0;
    ir_wen = 1'b0; ir_wdata = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        w16_en; logic [2:0] w16_sel; logic [15:0] w16_data;
    logic        w8_en;  logic [2:0] w8_sel;  logic [7:0]  w8_data;
    logic [3:0]  fm, fd;
    logic        i_en;   logic [1:0] i_sel;   logic        i_dec;
    logic        p_wen;  logic [15:0] p_data; logic        p_inc;
    logic [2:0]  c_sel;  logic c_pre; logic [15:0] e_pre, e_post;
    logic [7:0]  e_a, e_f; logic [15:0] e_sp, e_pc;
  } vec_t;

  vec_t tbl [18];

  initial begin
    clear_inputs();
    rst = 1'b1;

    tbl[0]  = '{1'b1, 1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 4'h0,4'h0, 1'b0,2'd0,1'b0, 1'b0,16'h0000,1'b0, 3'd2,1'b0,16'h0000,16'h014D, 8'h01,8'hB0,16'hFFFE,16'h0100};
    tbl[1]  = '{1'b0, 1'b1,3'd4,16'h12FF, 1'b0,3'd0,8'h00, 4'h0,4'h0, 1'b0,2'd0,1'b0, 1'b0,16'h0000,1'b0, 3'd4,1'b1,16'h01B0,16'h12F0, 8'h12,8'hF0,16'hFFFE,16'h0100};
    tbl[2]  = '{1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 4'b1001,4'b0000, 1'b0,2'd0,1'b0, 1'b0,16'h0000,1'b0, 3'd4,1'b1,16'h12F0,16'h1260, 8'h12,8'h60,16'hFFFE,16'h0100};
    tbl[3]  = '{1'b0, 1'b1,3'd3,16'h0000, 1'b0,3'd0,8'h00, 4'h0,4'h0, 1'b0,2'd0,1'b0, 1'b1,16'hFFFF,1'b0, 3'd3,1'b1,16'hFFFE,16'h0000, 8'h12,8'h60,16'h0000,16'hFFFF};
    tbl[4]  = '{1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 4'h0,4'h0, 1'b1,2'd3,1'b1, 1'b0,16'h0000,1'b1, 3'd3,1'b1,16'h0000,16'hFFFF, 8'h12,8'h60,16'hFFFF,16'h0000};
    tbl[5]  = '{1'b0, 1'b1,3'd2,16'hAAAA, 1'b1,3'd4,8'h55, 4'h0,4'h0, 1'b1,2'd2,1'b0, 1'b0,16'h0000,1'b0, 3'd2,1'b1,16'h014D,16'hAAAA, 8'h12,8'h60,16'hFFFF,16'h0000};
    tbl[6]  = '{1'b0, 1'b1,3'd2,16'h10FF, 1'b0,3'd0,8'h00, 4'h0,4'h0, 1'b0,2'd0,1'b0, 1'b0,16'h0000,1'b0, 3'd2,1'b1,16'hAAAA,16'h10FF, 8'h12,8'h60,16'hFFFF,16'h0000};
    tbl[7]  = '{1'b0, 1'b0,3'd0,16'h0000, 1'b1,3'd4,8'h55, 4'h0,4'h0, 1'b1,2'd2,1'b0, 1'b0,16'h0000,1'b0, 3'd2,1'b1,16'h10FF,16'h5500, 8'h12,8'h60,16'hFFFF,16'h0000};
    tbl[8]  = '{1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 4'h0,4'h0, 1'b0,2'd0,1'b0, 1'b1,16'h0038,1'b1, 3'd2,1'b1,16'h5500,16'h5500, 8'h12,8'h60,16'hFFFF,16'h0038};
    tbl[9]  = '{1'b0, 1'b1,3'd1,16'hFFFF, 1'b0,3'd0,8'h00, 4'h0,4'h0, 1'b0,2'd0,1'b0, 1'b0,16'h0000,1'b0, 3'd1,1'b1,16'h00D8,16'hFFFF, 8'h12,8'h60,16'hFFFF,16'h0038};
    tbl[10] = '{1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 4'h0,4'h0, 1'b1,2'd1,1'b0, 1'b0,16'h0000,1'b0, 3'd1,1'b1,16'hFFFF,16'h0000, 8'h12,8'h60,16'hFFFF,16'h0038};
    tbl[11] = '{1'b0, 1'b0,3'd0,16'h0000, 1'b1,3'd6,8'hFF, 4'h0,4'h0, 1'b0,2'd0,1'b0, 1'b0,16'h0000,1'b0, 3'd4,1'b1,16'h1260,16'h1260, 8'h12,8'h60,16'hFFFF,16'h0038};
    tbl[12] = '{1'b0, 1'b1,3'd7,16'h1234, 1'b0,3'd0,8'h00, 4'h0,4'h0, 1'b0,2'd0,1'b0, 1'b0,16'h0000,1'b0, 3'd4,1'b1,16'h1260,16'h1260, 8'h12,8'h60,16'hFFFF,16'h0038};
    tbl[13] = '{1'b0, 1'b0,3'd0,16'h0000, 1'b1,3'd0,8'h77, 4'h0,4'h0, 1'b0,2'd0,1'b0, 1'b0,16'h0000,1'b0, 3'd0,1'b1,16'h0013,16'h7713, 8'h12,8'h60,16'hFFFF,16'h0038};
    tbl[14] = '{1'b1, 1'b1,3'd2,16'h9999, 1'b1,3'd0,8'h77, 4'h0,4'h0, 1'b0,2'd0,1'b0, 1'b0,16'h0000,1'b0, 3'd0,1'b1,16'h7713,16'h0013, 8'h01,8'hB0,16'hFFFE,16'h0100};
    tbl[15] = '{1'b0, 1'b1,3'd4,16'hF00F, 1'b0,3'd0,8'h00, 4'h0,4'h0, 1'b0,2'd0,1'b0, 1'b0,16'h0000,1'b0, 3'd4,1'b1,16'h01B0,16'hF000, 8'hF0,8'h00,16'hFFFE,16'h0100};
    tbl[16] = '{1'b0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,8'h00, 4'b0110,4'b1111, 1'b0,2'd0,1'b0, 1'b0,16'h0000,1'b0, 3'd4,1'b1,16'hF000,16'hF060, 8'hF0,8'h60,16'hFFFE,16'h0100};
    tbl[17] = '{1'b0, 1'b1,3'd4,16'h0000, 1'b0,3'd0,8'h00, 4'b1111,4'b1111, 1'b0,2'd0,1'b0, 1'b0,16'h0000,1'b0, 3'd4,1'b1,16'hF060,16'h0000, 8'h00,8'h00,16'hFFFE,16'h0100};

    #2;
    for (int i = 0; i < 18; i++) begin
      clear_inputs();
      rst = tbl[i].rst;
      wr16_en = tbl[i].w16_en; wr16_sel = tbl[i].w16_sel; wr16_data = tbl[i].w16_data;
      wr8_en = tbl[i].w8_en; wr8_sel = tbl[i].w8_sel; wr8_data = tbl[i].w8_data;
      f_wmask = tbl[i].fm; f_wdata = tbl[i].fd;
      idu_en = tbl[i].i_en; idu_sel = tbl[i].i_sel; idu_dec = tbl[i].i_dec;
      pc_wen = tbl[i].p_wen; pc_wdata = tbl[i].p_data; pc_inc = tbl[i].p_inc;
      rd16_sel = tbl[i].c_sel;
      #1;
      if (tbl[i].c_pre) chk($sformatf("tbl%0d_rd16_pre", i), rd16_data, tbl[i].e_pre);
      tick();
      chk($sformatf("tbl%0d_rd16_post", i), rd16_data, tbl[i].e_post);
      chk($sformatf("tbl%0d_a", i), {8'h00, a_q}, {8'h00, tbl[i].e_a});
      chk($sformatf("tbl%0d_f", i), {8'h00, f_q}, {8'h00, tbl[i].e_f});
      chk($sformatf("tbl%0d_sp", i), sp_q, tbl[i].e_sp);
      chk($sformatf("tbl%0d_pc", i), pc_q, tbl[i].e_pc);
    end

    // State now: AF 0000, BC 0013, DE 00D8, HL 014D, SP FFFE, PC 0100.
    clear_inputs();
    ir_wen = 1'b1; ir_wdata = 8'hA5;
    #1;
    chk("ir_before_load", {8'h00, ir_q}, 16'h0000);
    tick();
    chk("ir_load", {8'h00, ir_q}, 16'h00A5);
    ir_wen = 1'b0; ir_wdata = 8'h3C;
    tick();
    chk("ir_hold", {8'h00, ir_q}, 16'h00A5);
    rd8_sel = {3'd6, 3'd4};
    #1;
    chk("rd8_h", {8'h00, rd8_data[7:0]}, 16'h0001);
    chk("rd8_none", {8'h00, rd8_data[15:8]}, 16'h0000);
    rd8_sel = {3'd7, 3'd5};
    #1;
    chk("rd8_l", {8'h00, rd8_data[7:0]}, 16'h004D);
    chk("rd8_a", {8'h00, rd8_data[15:8]}, 16'h0000);
    rst = 1'b1; ir_wen = 1'b1; ir_wdata = 8'h77;
    tick();
    chk("ir_reset", {8'h00, ir_q}, 16'h0000);

    // Randomized run against the reference model.
    clear_inputs();
    rst = 1'b1;
    tick();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 40) == 0);
      rd8_sel   = 6'($urandom);
      rd16_sel  = 3'($urandom);
      wr8_en    = ($urandom_range(0, 2) == 0);
      wr8_sel   = 3'($urandom);
      wr8_data  = 8'($urandom);
      wr16_en   = ($urandom_range(0, 3) == 0);
      wr16_sel  = 3'($urandom);
      wr16_data = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      f_wmask   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      f_wdata   = 4'($urandom);
      idu_en    = ($urandom_range(0, 1) == 0);
      idu_sel   = 2'($urandom);
      idu_dec   = 1'($urandom);
      pc_wen    = ($urandom_range(0, 5) == 0);
      pc_wdata  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      pc_inc    = 1'($urandom);
      ir_wen    = ($urandom_range(0, 3) == 0);
      ir_wdata  = 8'($urandom);
      #1;
      for (int p = 0; p < 2; p++)
        chk($sformatf("rnd%0d_rd8_%0d", c, p), {8'h00, rd8_data[8*p +: 8]}, {8'h00, mread8(rd8_sel[3*p +: 3])});
      chk($sformatf("rnd%0d_rd16", c), rd16_data, mread16(rd16_sel));
      chk($sformatf("rnd%0d_a", c), {8'h00, a_q}, {8'h00, m[7]});
      chk($sformatf("rnd%0d_f", c), {8'h00, f_q}, {8'h00, m[6]});
      chk($sformatf("rnd%0d_sp", c), sp_q, msp);
      chk($sformatf("rnd%0d_pc", c), pc_q, mpc);
      chk($sformatf("rnd%0d_ir", c), {8'h00, ir_q}, {8'h00, mir});
      model_step();
      tick();
    end

    clear_inputs();
    #1;
    chk("final_af", {a_q, f_q}, {m[7], m[6]});
    chk("final_sp", sp_q, msp);
    chk("final_pc", pc_q, mpc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
